// File: rtl/carry_select_seq_adder.sv
// Block-serial carry-select adder: WIDTH-bit add done BLOCK bits per clock over WIDTH/BLOCK cycles.
// Optional signed-overflow output is enabled by defining CSA_OVERFLOW_EN. WIDTH must be a multiple of BLOCK.
module carry_select_seq_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
`ifdef CSA_OVERFLOW_EN
  output logic             Overflow,
`endif
  output logic [1:0]       state_dbg
);

  localparam int N     = WIDTH / BLOCK;
  localparam int BLK_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [BLK_W-1:0] blk_q;

  logic [BLOCK-1:0] a_blk;
  logic [BLOCK-1:0] b_blk;
  logic [BLOCK:0]   s0;
  logic [BLOCK:0]   s1;
  logic [BLOCK:0]   sel;
  logic             last_blk;

  // Handshake: Start is a request that is taken on a rising edge only when
  // Busy=0 (IDLE or DONE); A, B, Cin are sampled on that same edge. Done is a
  // one-cycle valid pulse for Sum/Cout with no back-pressure from the consumer.

  // Both carry hypotheses for the current block; carry_q is the select.
  always_comb begin
    a_blk    = a_q[blk_q*BLOCK +: BLOCK];
    b_blk    = b_q[blk_q*BLOCK +: BLOCK];
    s0       = {1'b0, a_blk} + {1'b0, b_blk};
    s1       = s0 + (BLOCK+1)'(1);
    sel      = carry_q ? s1 : s0;
    last_blk = (blk_q == LAST_BLK);
  end

`ifdef CSA_OVERFLOW_EN
  logic ovf_next;
  // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ sum.
  assign ovf_next = a_blk[BLOCK-1] ^ b_blk[BLOCK-1] ^ sel[BLOCK-1] ^ sel[BLOCK];
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      blk_q   <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
`ifdef CSA_OVERFLOW_EN
      Overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state   <= RUN;
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            blk_q   <= '0;
            Sum     <= '0;
            Cout    <= 1'b0;
`ifdef CSA_OVERFLOW_EN
            Overflow <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          Sum[blk_q*BLOCK +: BLOCK] <= sel[BLOCK-1:0];
          carry_q                   <= sel[BLOCK];
          blk_q                     <= blk_q + BLK_W'(1);
          if (last_blk) begin
            state <= DONE;
            Cout  <= sel[BLOCK];
`ifdef CSA_OVERFLOW_EN
            Overflow <= ovf_next;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy      = (state == RUN);
  assign Done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_carry_select_seq_adder.sv
// Bench for carry_select_seq_adder: directed literal cases plus random traffic against an arithmetic model.
// Build with CSA_OVERFLOW_EN defined to also cover the Overflow output.
module tb_carry_select_seq_adder;

  localparam int W   = 16;
  localparam int BLK = 4;
  localparam int N   = W / BLK;
  localparam int EW  = W + 2;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic [1:0]   state_dbg;
`ifdef CSA_OVERFLOW_EN
  logic         Overflow;
`endif

  carry_select_seq_adder #(.WIDTH(W), .BLOCK(BLK)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Busy     (Busy),
    .Done     (Done),
    .Sum      (Sum),
    .Cout     (Cout),
`ifdef CSA_OVERFLOW_EN
    .Overflow (Overflow),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int tests    = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks how many blocks remain; the visible partial Sum is just the low
  // blocks of the true total, and the result is released after N edges.
  logic [EW-1:0] exp_q[$];
  bit            model_init = 1'b0;
  int            m_rem      = 0;
  bit            m_done     = 1'b0;
  logic [W:0]    m_full     = '0;
  logic          m_ovf_pend = 1'b0;
  logic [W-1:0]  m_sum      = '0;
  logic          m_cout     = 1'b0;
  logic          m_ovf      = 1'b0;

  function automatic logic [W-1:0] low_mask(input int k);
    if (k * BLK >= W) return '1;
    return (W'(1) << (k * BLK)) - W'(1);
  endfunction

  function automatic logic signed_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W:0] full);
    return (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
  endfunction

  always @(posedge Clk) begin
    model_init = 1'b1;
    if (Reset) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
      exp_q.delete();
    end else if (m_rem == 0 && Start) begin
      m_full     = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};
      m_ovf_pend = signed_ovf(A, B, m_full);
      m_rem      = N;
      m_done     = 1'b0;
      m_sum      = '0;
      m_cout     = 1'b0;
      m_ovf      = 1'b0;
      exp_q.push_back({m_ovf_pend, m_full});
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      m_sum = m_full[W-1:0] & low_mask(N - m_rem);
      if (m_rem == 0) begin
        m_done = 1'b1;
        m_cout = m_full[W];
        m_ovf  = m_ovf_pend;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // ---------------- compare process / scoreboard ----------------
  always @(negedge Clk) begin
    logic [EW-1:0] item;
    if (model_init) begin
      check("busy", 64'(Busy), 64'(m_rem > 0));
      check("done", 64'(Done), 64'(m_done));
      check("sum", 64'(Sum), 64'(m_sum));
      check("cout", 64'(Cout), 64'(m_cout));
`ifdef CSA_OVERFLOW_EN
      check("overflow", 64'(Overflow), 64'(m_ovf));
`endif
      if (Done === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          failures++;
          $display("FAIL sb_unexpected_done: Done=1 with no pending request");
        end else begin
          item = exp_q.pop_front();
          check("sb_sum", 64'(Sum), 64'(item[W-1:0]));
          check("sb_cout", 64'(Cout), 64'(item[W]));
`ifdef CSA_OVERFLOW_EN
          check("sb_overflow", 64'(Overflow), 64'(item[W+1]));
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at the falling edge after the accepting edge E0.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit wait_first);
    if (wait_first) @(negedge Clk);
    A     = a;
    B     = b;
    Cin   = c;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 4 * N + 8; k++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        cyc = k;
        ok  = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      failures++;
      $display("FAIL done_timeout: no Done within cycle budget");
    end
  endtask

  task automatic run_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c, input logic [W-1:0] exp_sum, input logic exp_cout,
                              input logic exp_ovf);
    int cyc;
    bit ok;
    do_start(a, b, c, 1'b1);
    wait_done(cyc, ok);
    if (ok) begin
      check({name, "_latency"}, 64'(cyc), 64'(N));
      check({name, "_sum"}, 64'(Sum), 64'(exp_sum));
      check({name, "_cout"}, 64'(Cout), 64'(exp_cout));
`ifdef CSA_OVERFLOW_EN
      check({name, "_ovf"}, 64'(Overflow), 64'(exp_ovf));
`else
      if (exp_ovf === 1'bx) $display("note: unknown overflow expectation for %s", name);
`endif
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  cyc;
    bit  ok;
    int  seen;
    bit  b2b;
    int  mode;

    Reset = 1'b1;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    Cin   = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_sum", 64'(Sum), 64'd0);
    check("reset_cout", 64'(Cout), 64'd0);

    run_directed("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_directed("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_directed("t3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_directed("t4a", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_directed("t4b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Start while busy is ignored; Start during the Done cycle is taken.
    do_start(16'h0001, 16'h0001, 1'b0, 1'b1);
    @(negedge Clk);
    A     = 16'hAAAA;
    B     = 16'h5555;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(cyc, ok);
    if (ok) begin
      check("t5_ignored_sum", 64'(Sum), 64'h0002);
      check("t5_ignored_cout", 64'(Cout), 64'd0);
      do_start(16'hAAAA, 16'h5555, 1'b0, 1'b0);
      wait_done(cyc, ok);
      if (ok) begin
        check("t5_b2b_latency", 64'(cyc), 64'(N));
        check("t5_b2b_sum", 64'(Sum), 64'hFFFF);
        check("t5_b2b_cout", 64'(Cout), 64'd0);
      end
    end

    // Reset mid-run aborts the add.
    do_start(16'h0F0F, 16'h0101, 1'b0, 1'b1);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("t6_busy", 64'(Busy), 64'd0);
    check("t6_done", 64'(Done), 64'd0);
    check("t6_sum", 64'(Sum), 64'd0);
    check("t6_cout", 64'(Cout), 64'd0);
    seen = 0;
    repeat (3 * N) begin
      @(negedge Clk);
      if (Done === 1'b1) seen++;
    end
    check("t6_no_done", 64'(seen), 64'd0);
    run_directed("t6_after", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

    // Random traffic, checked cycle by cycle by the compare process.
    b2b = 1'b0;
    for (int it = 0; it < 60; it++) begin
      if (!b2b) repeat ($urandom_range(0, 2)) @(negedge Clk);
      do_start(W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)), !b2b);
      b2b  = 1'b0;
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        repeat ($urandom_range(0, N - 2)) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
      end else begin
        if (mode <= 3) begin
          @(negedge Clk);
          A     = W'($urandom());
          B     = W'($urandom());
          Cin   = 1'($urandom_range(0, 1));
          Start = 1'b1;
          @(negedge Clk);
          Start = 1'b0;
        end
        wait_done(cyc, ok);
        b2b = ok && ($urandom_range(0, 2) == 0);
      end
    end

    repeat (N + 4) @(negedge Clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
